// File: rtl/sat_arith_pkg.sv
// Shared saturating-arithmetic definitions: datapath widths, overflow encoding,
// and helpers that return the signed clamp limits for a given width.
package sat_arith_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int ACCUM_WIDTH = 2 * DATA_WIDTH;
    localparam int MAX_WIDTH   = 64;  // widest operand the limit helpers support

    typedef enum logic [1:0] {
        OVF_NONE = 2'b00,
        OVF_POS  = 2'b01,
        OVF_NEG  = 2'b10
    } ovf_e;

    // Most positive value of a width-bit signed number, zero-extended to MAX_WIDTH.
    function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
        return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
    endfunction

    // Most negative value of a width-bit signed number; its low width bits are 100..0.
    function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
        return ~sat_max(width);
    endfunction

endpackage

// File: rtl/signed_multiplier.sv
// Full-precision combinational signed multiplier; the stage-0 producer that feeds
// the saturating adder tree. The product width always holds the result exactly.
module signed_multiplier
    import sat_arith_pkg::*;
#(
    parameter int IN_WIDTH = DATA_WIDTH
) (
    input  logic [IN_WIDTH-1:0]   in_a,
    input  logic [IN_WIDTH-1:0]   in_b,
    output logic [2*IN_WIDTH-1:0] out_p
);

    logic [2*IN_WIDTH-1:0] w_a_ext;
    logic [2*IN_WIDTH-1:0] w_b_ext;

    // Sign-extending both operands first makes the truncated 2N-bit product exact.
    assign w_a_ext = {{IN_WIDTH{in_a[IN_WIDTH-1]}}, in_a};
    assign w_b_ext = {{IN_WIDTH{in_b[IN_WIDTH-1]}}, in_b};
    assign out_p   = w_a_ext * w_b_ext;

endmodule

// File: rtl/saturating_adder.sv
// Signed saturating adder: zero-latency clamped sum plus a registered, valid-qualified
// copy with overflow flags. Define SAT_ADD_STATS_EN to build the saturation event counter.
module saturating_adder
    import sat_arith_pkg::*;
#(
    parameter int WIDTH     = ACCUM_WIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [WIDTH-1:0]     out_sum,
    input  logic                 valid_in,
    output logic [WIDTH-1:0]     sum_q,
    output logic                 valid_q,
    output logic                 ovf_pos_q,
    output logic                 ovf_neg_q,
    output logic [CNT_WIDTH-1:0] sat_cnt
);

    localparam logic [MAX_WIDTH-1:0] SAT_MAX_EXT = sat_max(WIDTH);
    localparam logic [MAX_WIDTH-1:0] SAT_MIN_EXT = sat_min(WIDTH);
    localparam logic [WIDTH-1:0]     SAT_MAX     = SAT_MAX_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SAT_MIN     = SAT_MIN_EXT[WIDTH-1:0];

    logic [WIDTH:0]   w_sum_ext;
    ovf_e             w_ovf;
    logic [WIDTH-1:0] r_sum;
    logic             r_valid;
    ovf_e             r_ovf;

    assign w_sum_ext = {in_a[WIDTH-1], in_a} + {in_b[WIDTH-1], in_b};

    // The two top bits of the sign-extended sum disagree only when same-sign operands
    // overflowed; the extension bit then carries the true sign of the result.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_ovf   = OVF_NONE;
        out_sum = w_sum_ext[WIDTH-1:0];
        if (!w_sum_ext[WIDTH] && w_sum_ext[WIDTH-1]) begin
            w_ovf   = OVF_POS;
            out_sum = SAT_MAX;
        end else if (w_sum_ext[WIDTH] && !w_sum_ext[WIDTH-1]) begin
            w_ovf   = OVF_NEG;
            out_sum = SAT_MIN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= OVF_NONE;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_sum <= out_sum;
                r_ovf <= w_ovf;
            end
        end
    end

    assign sum_q     = r_sum;
    assign valid_q   = r_valid;
    assign ovf_pos_q = (r_ovf == OVF_POS);
    assign ovf_neg_q = (r_ovf == OVF_NEG);

`ifdef SAT_ADD_STATS_EN
    logic [CNT_WIDTH-1:0] r_sat_cnt;

    // Sticks at all-ones rather than wrapping back to a misleadingly small count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_cnt <= '0;
        end else if (valid_in && (w_ovf != OVF_NONE) && (r_sat_cnt != '1)) begin
            r_sat_cnt <= r_sat_cnt + CNT_WIDTH'(1);
        end
    end

    assign sat_cnt = r_sat_cnt;
`else
    assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_saturating_adder.sv
// Directed bench for saturating_adder (32-bit and 8-bit instances) and signed_multiplier;
// counter expectations follow SAT_ADD_STATS_EN.
module tb_saturating_adder;

`ifdef SAT_ADD_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_a, in_b;
    logic        valid_in;
    logic [31:0] out_sum, sum_q;
    logic        valid_q, ovf_pos_q, ovf_neg_q;
    logic [15:0] sat_cnt;

    logic [7:0]  s_a, s_b, s_sum, s_sum_q;
    logic        s_v, s_valid_q, s_pos, s_neg;
    logic [1:0]  s_cnt;

    logic [15:0] m_a, m_b;
    logic [31:0] m_p;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    saturating_adder #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .out_sum(out_sum),
        .valid_in(valid_in), .sum_q(sum_q), .valid_q(valid_q),
        .ovf_pos_q(ovf_pos_q), .ovf_neg_q(ovf_neg_q), .sat_cnt(sat_cnt)
    );

    saturating_adder #(.WIDTH(8), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .in_a(s_a), .in_b(s_b), .out_sum(s_sum),
        .valid_in(s_v), .sum_q(s_sum_q), .valid_q(s_valid_q),
        .ovf_pos_q(s_pos), .ovf_neg_q(s_neg), .sat_cnt(s_cnt)
    );

    signed_multiplier #(.IN_WIDTH(16)) mult (
        .in_a(m_a), .in_b(m_b), .out_p(m_p)
    );

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic v);
        @(negedge clk);
        in_a = a; in_b = b; valid_in = v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(32'd0, 32'd0, 1'b0);
        tick(); tick();
        n_vec++; if (sum_q !== 32'd0) begin n_err++; $display("FAIL reset_sum_q: got %h expected %h", sum_q, 32'd0); end
        n_vec++; if (valid_q !== 1'b0) begin n_err++; $display("FAIL reset_valid_q: got %b expected 0", valid_q); end
        n_vec++; if ({ovf_pos_q, ovf_neg_q} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b expected 00", {ovf_pos_q, ovf_neg_q}); end
        n_vec++; if (sat_cnt !== 16'd0) begin n_err++; $display("FAIL reset_sat_cnt: got %0d expected 0", sat_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        apply(32'd100, -32'sd30, 1'b1);
        n_vec++; if (out_sum !== 32'd70) begin n_err++; $display("FAIL basic_comb: got %h expected %h", out_sum, 32'd70); end
        tick();
        n_vec++; if (sum_q !== 32'd70) begin n_err++; $display("FAIL basic_sum_q: got %h expected %h", sum_q, 32'd70); end
        n_vec++; if (valid_q !== 1'b1) begin n_err++; $display("FAIL basic_valid_q: got %b expected 1", valid_q); end
        n_vec++; if ({ovf_pos_q, ovf_neg_q} !== 2'b00) begin n_err++; $display("FAIL basic_flags: got %b expected 00", {ovf_pos_q, ovf_neg_q}); end
    endtask

    task automatic test_max_no_ovf();
        apply(32'h7FFF_FFFE, 32'h0000_0001, 1'b1);
        n_vec++; if (out_sum !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL edge_max_comb: got %h expected %h", out_sum, 32'h7FFF_FFFF); end
        tick();
        n_vec++; if ({ovf_pos_q, ovf_neg_q} !== 2'b00) begin n_err++; $display("FAIL edge_max_flags: got %b expected 00", {ovf_pos_q, ovf_neg_q}); end
    endtask

    task automatic test_pos_sat();
        apply(32'h7FFF_FFF0, 32'h0000_0020, 1'b1);
        n_vec++; if (out_sum !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL pos_comb: got %h expected %h", out_sum, 32'h7FFF_FFFF); end
        tick();
        exp_cnt += 16'(STATS);
        n_vec++; if (sum_q !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL pos_sum_q: got %h expected %h", sum_q, 32'h7FFF_FFFF); end
        n_vec++; if ({ovf_pos_q, ovf_neg_q} !== 2'b10) begin n_err++; $display("FAIL pos_flags: got %b expected 10", {ovf_pos_q, ovf_neg_q}); end
        n_vec++; if (sat_cnt !== exp_cnt) begin n_err++; $display("FAIL pos_sat_cnt: got %0d expected %0d", sat_cnt, exp_cnt); end
    endtask

    // Invalid cycle carrying a would-be negative overflow: registered state must hold.
    task automatic test_hold();
        apply(32'h8000_0000, 32'h8000_0000, 1'b0);
        n_vec++; if (out_sum !== 32'h8000_0000) begin n_err++; $display("FAIL hold_comb: got %h expected %h", out_sum, 32'h8000_0000); end
        tick();
        n_vec++; if (valid_q !== 1'b0) begin n_err++; $display("FAIL hold_valid_q: got %b expected 0", valid_q); end
        n_vec++; if (sum_q !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL hold_sum_q: got %h expected %h", sum_q, 32'h7FFF_FFFF); end
        n_vec++; if ({ovf_pos_q, ovf_neg_q} !== 2'b10) begin n_err++; $display("FAIL hold_flags: got %b expected 10", {ovf_pos_q, ovf_neg_q}); end
        n_vec++; if (sat_cnt !== exp_cnt) begin n_err++; $display("FAIL hold_sat_cnt: got %0d expected %0d", sat_cnt, exp_cnt); end
    endtask

    task automatic test_neg_sat();
        apply(32'h8000_0005, 32'hFFFF_FFF0, 1'b1);
        n_vec++; if (out_sum !== 32'h8000_0000) begin n_err++; $display("FAIL neg_comb: got %h expected %h", out_sum, 32'h8000_0000); end
        tick();
        exp_cnt += 16'(STATS);
        n_vec++; if (sum_q !== 32'h8000_0000) begin n_err++; $display("FAIL neg_sum_q: got %h expected %h", sum_q, 32'h8000_0000); end
        n_vec++; if ({ovf_pos_q, ovf_neg_q} !== 2'b01) begin n_err++; $display("FAIL neg_flags: got %b expected 01", {ovf_pos_q, ovf_neg_q}); end
        apply(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        n_vec++; if (out_sum !== 32'h8000_0000) begin n_err++; $display("FAIL neg_min_comb: got %h expected %h", out_sum, 32'h8000_0000); end
        tick();
        exp_cnt += 16'(STATS);
        n_vec++; if ({ovf_pos_q, ovf_neg_q} !== 2'b01) begin n_err++; $display("FAIL neg_min_flags: got %b expected 01", {ovf_pos_q, ovf_neg_q}); end
        n_vec++; if (sat_cnt !== exp_cnt) begin n_err++; $display("FAIL neg_sat_cnt: got %0d expected %0d", sat_cnt, exp_cnt); end
    endtask

    task automatic test_mixed();
        apply(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        n_vec++; if (out_sum !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mixed_comb: got %h expected %h", out_sum, 32'hFFFF_FFFF); end
        tick();
        n_vec++; if (sum_q !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mixed_sum_q: got %h expected %h", sum_q, 32'hFFFF_FFFF); end
        n_vec++; if ({ovf_pos_q, ovf_neg_q} !== 2'b00) begin n_err++; $display("FAIL mixed_flags: got %b expected 00", {ovf_pos_q, ovf_neg_q}); end
        n_vec++; if (sat_cnt !== exp_cnt) begin n_err++; $display("FAIL mixed_sat_cnt: got %0d expected %0d", sat_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        apply(32'd1, 32'd2, 1'b1);
        tick();
        n_vec++; if (sum_q !== 32'd3) begin n_err++; $display("FAIL b2b_first: got %h expected %h", sum_q, 32'd3); end
        apply(-32'sd4, 32'd1, 1'b1);
        tick();
        n_vec++; if (sum_q !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL b2b_second: got %h expected %h", sum_q, 32'hFFFF_FFFD); end
        n_vec++; if (valid_q !== 1'b1) begin n_err++; $display("FAIL b2b_valid_q: got %b expected 1", valid_q); end
    endtask

    task automatic test_reset_wins();
        rst = 1'b1;
        apply(32'h7FFF_FFFF, 32'd1, 1'b1);
        tick();
        exp_cnt = '0;
        n_vec++; if (sum_q !== 32'd0) begin n_err++; $display("FAIL rstwin_sum_q: got %h expected %h", sum_q, 32'd0); end
        n_vec++; if (valid_q !== 1'b0) begin n_err++; $display("FAIL rstwin_valid_q: got %b expected 0", valid_q); end
        n_vec++; if ({ovf_pos_q, ovf_neg_q} !== 2'b00) begin n_err++; $display("FAIL rstwin_flags: got %b expected 00", {ovf_pos_q, ovf_neg_q}); end
        n_vec++; if (sat_cnt !== exp_cnt) begin n_err++; $display("FAIL rstwin_sat_cnt: got %0d expected %0d", sat_cnt, exp_cnt); end
        rst = 1'b0;
        apply(32'd0, 32'd0, 1'b0);
    endtask

    // Five saturating adds into a 2-bit counter: it must stop at 3.
    task automatic test_small_width();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_a = 8'h70; s_b = 8'h70; s_v = 1'b1;
            #1;
            n_vec++; if (s_sum !== 8'h7F) begin n_err++; $display("FAIL small_pos_comb[%0d]: got %h expected 7f", i, s_sum); end
            tick();
            n_vec++; if ({s_pos, s_neg} !== 2'b10) begin n_err++; $display("FAIL small_pos_flags[%0d]: got %b expected 10", i, {s_pos, s_neg}); end
        end
        @(negedge clk);
        s_a = 8'h80; s_b = 8'h80; s_v = 1'b0;
        #1;
        n_vec++; if (s_sum !== 8'h80) begin n_err++; $display("FAIL small_neg_comb: got %h expected 80", s_sum); end
        n_vec++; if (s_cnt !== 2'(3 * STATS)) begin n_err++; $display("FAIL small_cnt_ceiling: got %0d expected %0d", s_cnt, 3 * STATS); end
        s_a = 8'h80; s_b = 8'h7F;
        #1;
        n_vec++; if (s_sum !== 8'hFF) begin n_err++; $display("FAIL small_mixed_comb: got %h expected ff", s_sum); end
    endtask

    task automatic test_multiplier();
        m_a = -16'sd3; m_b = 16'sd7; #1;
        n_vec++; if (m_p !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_neg: got %h expected %h", m_p, 32'hFFFF_FFEB); end
        m_a = 16'h8000; m_b = 16'h8000; #1;
        n_vec++; if (m_p !== 32'h4000_0000) begin n_err++; $display("FAIL mul_minmin: got %h expected %h", m_p, 32'h4000_0000); end
        m_a = 16'h7FFF; m_b = 16'h7FFF; #1;
        n_vec++; if (m_p !== 32'h3FFF_0001) begin n_err++; $display("FAIL mul_maxmax: got %h expected %h", m_p, 32'h3FFF_0001); end
        m_a = 16'h8000; m_b = 16'h7FFF; #1;
        n_vec++; if (m_p !== 32'hC000_8000) begin n_err++; $display("FAIL mul_minmax: got %h expected %h", m_p, 32'hC000_8000); end
    endtask

    initial begin
        in_a = '0; in_b = '0; valid_in = 1'b0; rst = 1'b1;
        s_a = '0; s_b = '0; s_v = 1'b0;
        m_a = '0; m_b = '0;
        test_reset();
        test_basic();
        test_max_no_ovf();
        test_pos_sat();
        test_hold();
        test_neg_sat();
        test_mixed();
        test_back_to_back();
        test_reset_wins();
        test_small_width();
        test_multiplier();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
